// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, drives the byte
//                address to a combinational instruction memory, captures the
//                returned word into the IF/ID register, predecodes J for a
//                zero-bubble redirect, honours downstream stall / branch
//                redirect, and freezes permanently on the HALT word.
//  Ports       : clk, rst (async, active high)
//                stall, redirect_valid, redirect_target[31:0]  - from downstream
//                imem_addr[31:0] out / imem_ins[31:0] in       - instruction memory
//                if_id_ins, if_id_pc4, if_id_valid             - IF/ID register
//                halted, fetch_count[31:0]                     - status
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_0029
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [5:0]  C_OP_J      = 6'b000010;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_ins_q, if_id_ins_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc4;
  logic [31:0] jump_target;

  assign pc4 = pc_q + 32'd4;
  // The J field is already a byte address; it is not shifted, only aligned.
  assign jump_target = {pc4[31:26], imem_ins[25:0]} & C_WORD_MASK;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_ins_d   = if_id_ins_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;

    if (state_q == S_HALT) begin
      // Frozen: PC holds, pipeline is fed bubbles, downstream requests ignored.
      if_id_ins_d   = 32'd0;
      if_id_pc4_d   = 32'd0;
      if_id_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall: the wrong-path word is squashed.
      pc_d          = redirect_target & C_WORD_MASK;
      if_id_ins_d   = 32'd0;
      if_id_pc4_d   = 32'd0;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      if_id_ins_d   = imem_ins;
      if_id_pc4_d   = pc4;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      if (imem_ins == HALT_WORD) begin
        state_d = S_HALT;
      end else if (imem_ins[31:26] == C_OP_J) begin
        pc_d = jump_target;
      end else begin
        pc_d = pc4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC & C_WORD_MASK;
      if_id_ins_q   <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_ins_q   <= if_id_ins_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_ins   = if_id_ins_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A 64-word instruction
//                memory answers combinationally; an architectural model of
//                the fetch rules predicts all outputs, compared every cycle,
//                with directed literal checks on the key scenarios followed
//                by randomized programs, stalls and redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_HALT = 32'h0000_0029;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_ins;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];

  int vectors = 0;
  int miscompares = 0;

  // Architectural model state
  logic [31:0] m_pc, m_ins, m_pc4, m_cnt;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  assign imem_ins = mem[imem_addr[7:2]];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_ins       (imem_ins),
    .if_id_ins      (if_id_ins),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ins = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_halted = 1'b0; m_cnt = 32'd0;
  endtask

  // One clock edge of the fetch rules, evaluated from the model's own PC.
  task automatic model_step();
    logic [31:0] w, np;
    if (m_halted) begin
      m_ins = 0; m_pc4 = 0; m_valid = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_target & ~32'd3;
      m_ins = 0; m_pc4 = 0; m_valid = 0;
    end else if (!stall) begin
      w  = mem[m_pc[7:2]];
      np = m_pc + 32'd4;
      m_ins = w; m_pc4 = np; m_valid = 1; m_cnt = m_cnt + 1;
      if (w == C_HALT)             m_halted = 1;
      else if (w[31:26] == 6'd2)   m_pc = {np[31:26], w[25:0]} & ~32'd3;
      else                         m_pc = np;
    end
  endtask

  task automatic compare();
    chk("imem_addr",   imem_addr,          m_pc);
    chk("if_id_ins",   if_id_ins,          m_ins);
    chk("if_id_pc4",   if_id_pc4,          m_pc4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("halted",      {31'd0, halted},    {31'd0, m_halted});
    chk("fetch_count", fetch_count,        m_cnt);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask

  task automatic fill_random();
    int r;
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        w = C_HALT;
      end else if (r < 18) begin
        w = {6'd2, 18'd0, 8'($urandom_range(0, 255))};
      end else begin
        w = $urandom;
        if (w[31:26] == 6'd2) w[31:26] = 6'd8;
        if (w == C_HALT) w = 32'h2000_0001;
      end
      mem[i] = w;
    end
  endtask

  int halt_age;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
    mem[5]  = 32'h0800_0050;
    mem[31] = C_HALT;
    model_reset();
    #3;
    apply_reset();

    // Sequential fetch and stall at PC 0x8
    cycle();
    chk("seq_addr1", imem_addr, 32'h4);
    chk("seq_pc4_1", if_id_pc4, 32'h4);
    cycle();
    chk("seq_addr2", imem_addr, 32'h8);
    stall = 1'b1;
    cycle(); cycle();
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc4",  if_id_pc4, 32'h8);
    chk("stall_cnt",  fetch_count, 32'd2);
    stall = 1'b0;
    cycle();
    chk("resume_addr", imem_addr, 32'hC);
    chk("resume_pc4",  if_id_pc4, 32'hC);
    chk("seq_cnt3",    fetch_count, 32'd3);
    cycle(); cycle();
    chk("at_0x14", imem_addr, 32'h14);

    // Asynchronous reset mid-cycle at PC 0x14
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr",   imem_addr, 32'h0);
    chk("arst_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_cnt",    fetch_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare();

    // Run to 0x14 again, then J to 0x50
    repeat (5) cycle();
    cycle();
    chk("j_addr",  imem_addr, 32'h50);
    chk("j_ins",   if_id_ins, 32'h0800_0050);
    chk("j_pc4",   if_id_pc4, 32'h18);
    chk("j_valid", {31'd0, if_id_valid}, 32'd1);

    // Redirect beats stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h66;
    cycle();
    chk("redir_addr",  imem_addr, 32'h64);
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    stall = 1'b0; redirect_valid = 1'b0;

    // Run to HALT at 0x7C
    repeat (6) cycle();
    chk("pre_halt_addr", imem_addr, 32'h7C);
    cycle();
    chk("halt_ins",    if_id_ins, C_HALT);
    chk("halt_valid",  {31'd0, if_id_valid}, 32'd1);
    chk("halt_flag",   {31'd0, halted}, 32'd1);
    chk("halt_cnt",    fetch_count, 32'd13);
    redirect_valid = 1'b1; redirect_target = 32'h0;
    cycle();
    chk("halted_addr",  imem_addr, 32'h7C);
    chk("halted_valid", {31'd0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;

    // Randomized programs, stalls and redirects
    for (int round = 0; round < 6; round++) begin
      fill_random();
      apply_reset();
      halt_age = 0;
      for (int c = 0; c < 250; c++) begin
        stall           = ($urandom_range(0, 99) < 20);
        redirect_valid  = ($urandom_range(0, 99) < 10);
        redirect_target = 32'($urandom_range(0, 255));
        cycle();
        if (m_halted) halt_age++;
        if (halt_age > 4) begin
          stall = 1'b0; redirect_valid = 1'b0;
          apply_reset();
          halt_age = 0;
        end
      end
      stall = 1'b0; redirect_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the instruction memory's byte address and captures the returned word into the IF/ID pipeline register for the decoder. It holds the PC, computes the sequential next PC, and predecodes `J` to redirect with zero bubbles. It applies downstream stall and branch-redirect requests and stops fetching permanently on `HALT`. The instruction memory is purely combinational (`ins = memory[addr>>2]`), so fetch issues an address and consumes the instruction in the same cycle.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `HALT_WORD`, 32'h0000_0029, encoding (opcode 0, funct 101001) that stops fetch.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and IF/ID for this cycle.
- `redirect_valid`  in  1  taken branch resolved downstream.
- `redirect_target`  in  32  byte address of the redirect.
- `imem_addr`  out  32  byte address to the instruction memory; equals the PC register.
- `imem_ins`  in  32  instruction word from the instruction memory, same cycle.
- `if_id_ins`  out  32  registered instruction for decode.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `halted`  out  1  HALT accepted; fetch is frozen.
- `fetch_count`  out  32  number of instructions accepted into IF/ID.

## Operation
- The PC register's bits [1:0] are always 0. Low two bits of `redirect_target` and of jump targets are discarded.
- Accept condition: `!halted && !redirect_valid && !stall`. When accepted, IF/ID loads `{imem_ins, pc+4, valid=1}` and `fetch_count` increments, wrapping modulo 2^32.
- Next PC, first matching rule wins:
  1. `halted` = 1: PC holds.
  2. `redirect_valid` = 1: PC ← `redirect_target`. IF/ID ← bubble (ins 0, pc4 0, valid 0). This applies even when `stall` = 1.
  3. `stall` = 1: PC, IF/ID and `fetch_count` hold.
  4. `imem_ins` == `HALT_WORD`: accept the word. PC holds at the HALT address. `halted` ← 1.
  5. `imem_ins[31:26]` == 6'b000010 (`J`): accept the word. PC ← `{pc4[31:26], imem_ins[25:0]}` with bits [1:0] forced to 0. The jump field is a byte address and is not shifted.
  6. Otherwise: accept the word. PC ← pc+4, wrapping modulo 2^32.
- While halted, every cycle after the HALT word loads IF/ID with a bubble. `redirect_valid` and `stall` are ignored. Only `rst` clears `halted`.
- `J` is not sent downstream for resolution. It reaches IF/ID only so decode can treat it as a no-op. BEQ/BNE are resolved downstream and return through `redirect_*`.
- States: RUN (`halted` = 0) and HALT (`halted` = 1). RUN→HALT on an accepted HALT word. HALT→RUN only on `rst`.

## Timing
- Reset, asynchronous: PC = `RESET_PC`, `imem_addr` = `RESET_PC`, `if_id_ins` = 0, `if_id_pc4` = 0, `if_id_valid` = 0, `halted` = 0, `fetch_count` = 0. If `rst` asserts mid-operation, all of these change immediately, without waiting for a clock edge.
- The first fetch after `rst` falls uses the first rising edge: IF/ID captures `memory[RESET_PC>>2]`.
- `imem_addr` changes only on a clock edge or on reset; it has no combinational path from any input.
- Fetch latency: the word addressed in cycle N appears on `if_id_*` after edge N+1.
- Redirect: one bubble. The target address is presented in the cycle after `redirect_valid` is sampled.
- `J`: zero bubbles. The target address is presented in the cycle immediately after the `J` is fetched.
- `halted` rises on the same edge that loads HALT into IF/ID.

## Test plan
- Reset: assert `rst` asynchronously mid-run at PC 0x14 → `imem_addr` = 0, `if_id_valid` = 0, `halted` = 0 and `fetch_count` = 0 immediately, before any clock edge.
- Sequential fetch: memory returns ADDI words at 0x0, 0x4, 0x8 → `imem_addr` steps 0, 4, 8; `if_id_pc4` is 4, 8, 12 one cycle later; `fetch_count` = 3.
- Jump predecode: `imem_ins` = 32'h0800_0050 at PC 0x14 → next `imem_addr` = 0x50; IF/ID = {0x08000050, pc4 0x18, valid 1}; no bubble.
- Stall: hold `stall` high for 2 cycles at PC 0x8 → `imem_addr` stays 0x8; IF/ID and `fetch_count` are unchanged; fetch resumes at 0x8.
- Redirect beats stall: `stall` = 1 and `redirect_valid` = 1 with target 0x66 in the same cycle → next `imem_addr` = 0x64; `if_id_valid` = 0.
- Halt: `imem_ins` = 32'h0000_0029 at PC 0x7C → IF/ID holds the HALT word with valid 1 and `halted` = 1. Afterwards `imem_addr` stays 0x7C, `if_id_valid` = 0, and a later redirect to 0x0 is ignored.
